// File: rtl/elevator_shaft_model.sv
// Shaft plant for the 4-floor elevator controller: car position,
// floor sensors, door stroke and latched command faults.
module elevator_shaft_model #(
  parameter int STEPS_PER_FLOOR = 4,
  parameter int TICKS_PER_STEP  = 2,
  parameter int DOOR_TICKS      = 3,
  parameter int START_FLOOR     = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       motor1,
  input  logic       motor2,
  input  logic       porta,
  output logic       sen1,
  output logic       sen2,
  output logic       sen3,
  output logic       sen4,
  output logic       sp,
  output logic [1:0] floor_idx,
  output logic       moving,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int POS_MAX = 3 * STEPS_PER_FLOOR;
  localparam int PW = $clog2(POS_MAX + 1);
  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int DW = $clog2(DOOR_TICKS + 1);

  localparam logic [PW-1:0] POS_RST = PW'(START_FLOOR * STEPS_PER_FLOOR);
  localparam logic [PW-1:0] POS_TOP = PW'(POS_MAX);
  localparam logic [PW-1:0] POS_ONE = PW'(1);
  localparam logic [PW-1:0] FL1 = PW'(STEPS_PER_FLOOR);
  localparam logic [PW-1:0] FL2 = PW'(2 * STEPS_PER_FLOOR);
  localparam logic [TW-1:0] PRE_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [TW-1:0] PRE_ONE = TW'(1);
  localparam logic [DW-1:0] D_FULL = DW'(DOOR_TICKS);
  localparam logic [DW-1:0] D_ONE = DW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_UP    = 2'd1;
  localparam logic [1:0] S_DOWN  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] D_CLOSED  = 2'd0;
  localparam logic [1:0] D_OPENING = 2'd1;
  localparam logic [1:0] D_OPEN    = 2'd2;
  localparam logic [1:0] D_CLOSING = 2'd3;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_BOTH = 2'b01;
  localparam logic [1:0] C_UNSAFE = 2'b10;
  localparam logic [1:0] C_OVER = 2'b11;

  logic [PW-1:0] pos, pos_n;
  logic [TW-1:0] pre, pre_n;
  logic [DW-1:0] dcnt, dcnt_n, dcnt_s;
  logic [1:0] car, car_n, tgt;
  logic [1:0] door, door_n, door_s;
  logic [1:0] code_n, floor_n;
  logic both, car_mv, tgt_mv, wrap, stepping, over, unsafe;

  // Door stroke if the door were allowed to move this edge
  always_comb begin
    dcnt_s = dcnt;
    if (porta && dcnt != D_FULL) begin
      dcnt_s = dcnt + D_ONE;
    end else if (!porta && dcnt != '0) begin
      dcnt_s = dcnt - D_ONE;
    end
    priority case (1'b1)
      (dcnt_s == '0):     door_s = D_CLOSED;
      (dcnt_s == D_FULL): door_s = D_OPEN;
      porta:              door_s = D_OPENING;
      default:            door_s = D_CLOSING;
    endcase
  end

  always_comb begin
    both = motor1 & motor2;
    priority case (1'b1)
      (motor2 & ~motor1): tgt = S_UP;
      (motor1 & ~motor2): tgt = S_DOWN;
      default:            tgt = S_IDLE;
    endcase
    car_mv = (car == S_UP) || (car == S_DOWN);
    tgt_mv = (tgt == S_UP) || (tgt == S_DOWN);
    wrap = (pre == PRE_LAST);
    stepping = tgt_mv && (car == tgt) && wrap;
    over = stepping &&
      (((tgt == S_UP) && (pos == POS_TOP)) ||
       ((tgt == S_DOWN) && (pos == '0)));
    // A door that is open, or being asked to open, forbids motion
    unsafe = ((car_mv || tgt_mv) && porta) ||
      (tgt_mv && (car != tgt) && (door != D_CLOSED));
  end

  always_comb begin
    car_n = car;
    pos_n = pos;
    pre_n = pre;
    door_n = door;
    dcnt_n = dcnt;
    code_n = fault_code;
    if (car != S_FAULT) begin
      priority case (1'b1)
        both: begin
          car_n = S_FAULT;
          code_n = C_BOTH;
        end
        unsafe: begin
          car_n = S_FAULT;
          code_n = C_UNSAFE;
        end
        over: begin
          car_n = S_FAULT;
          code_n = C_OVER;
        end
        default: begin
          car_n = tgt;
          door_n = door_s;
          dcnt_n = dcnt_s;
          if (!tgt_mv || (tgt != car)) begin
            pre_n = '0;
          end else begin
            pre_n = wrap ? '0 : pre + PRE_ONE;
          end
          if (stepping) begin
            pos_n = (tgt == S_UP) ? pos + POS_ONE : pos - POS_ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    floor_n = floor_idx;
    priority case (1'b1)
      (pos_n == '0):      floor_n = 2'd0;
      (pos_n == FL1):     floor_n = 2'd1;
      (pos_n == FL2):     floor_n = 2'd2;
      (pos_n == POS_TOP): floor_n = 2'd3;
      default:            floor_n = floor_idx;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= POS_RST;
      pre <= '0;
      car <= S_IDLE;
      door <= D_CLOSED;
      dcnt <= '0;
      fault_code <= C_NONE;
      sp <= 1'b0;
      floor_idx <= 2'(START_FLOOR);
    end else begin
      pos <= pos_n;
      pre <= pre_n;
      car <= car_n;
      door <= door_n;
      dcnt <= dcnt_n;
      fault_code <= code_n;
      sp <= (door_n != D_CLOSED);
      floor_idx <= floor_n;
    end
  end

  assign sen1 = (pos == '0);
  assign sen2 = (pos == FL1);
  assign sen3 = (pos == FL2);
  assign sen4 = (pos == POS_TOP);
  assign moving = (car == S_UP) || (car == S_DOWN);
  assign fault = (car == S_FAULT);

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Directed bench for the elevator shaft plant with default parameters,
// checking sensors, door, faults and async reset.
module tb_elevator_shaft_model;

  logic clock = 1'b0;
  logic reset, motor1, motor2, porta;
  logic sen1, sen2, sen3, sen4, sp, moving, fault;
  logic [1:0] floor_idx, fault_code;
  logic [3:0] sens;
  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  assign sens = {sen4, sen3, sen2, sen1};

  elevator_shaft_model dut (
    .clock(clock),
    .reset(reset),
    .motor1(motor1),
    .motor2(motor2),
    .porta(porta),
    .sen1(sen1),
    .sen2(sen2),
    .sen3(sen3),
    .sen4(sen4),
    .sp(sp),
    .floor_idx(floor_idx),
    .moving(moving),
    .fault(fault),
    .fault_code(fault_code)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    motor1 = 0;
    motor2 = 0;
    porta = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1;
    motor1 = 0;
    motor2 = 0;
    porta = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_sens", 8'(sens), 8'h1);
    chk("rst_sp", 8'(sp), 8'h0);
    chk("rst_floor", 8'(floor_idx), 8'h0);
    chk("rst_moving", 8'(moving), 8'h0);
    chk("rst_fault", 8'(fault), 8'h0);
    chk("rst_code", 8'(fault_code), 8'h0);

    // 1: up one floor
    motor2 = 1;
    edges(1);
    chk("up_moving", 8'(moving), 8'h1);
    chk("up_e0_sens", 8'(sens), 8'h1);
    edges(2);
    chk("up_e2_sens", 8'(sens), 8'h0);
    edges(5);
    chk("up_e7_sens", 8'(sens), 8'h0);
    chk("up_e7_floor", 8'(floor_idx), 8'h0);
    edges(1);
    chk("up_e8_sens", 8'(sens), 8'h2);
    chk("up_e8_floor", 8'(floor_idx), 8'h1);
    motor2 = 0;
    edges(1);
    chk("up_idle_mov", 8'(moving), 8'h0);
    chk("up_idle_sens", 8'(sens), 8'h2);

    // 2: down to bottom and beyond
    motor1 = 1;
    edges(9);
    chk("dn_e8_sens", 8'(sens), 8'h1);
    chk("dn_e8_floor", 8'(floor_idx), 8'h0);
    edges(1);
    chk("dn_e9_fault", 8'(fault), 8'h0);
    edges(1);
    chk("dn_ot_fault", 8'(fault), 8'h1);
    chk("dn_ot_code", 8'(fault_code), 8'h3);
    chk("dn_ot_mov", 8'(moving), 8'h0);
    chk("dn_ot_sens", 8'(sens), 8'h1);
    motor1 = 0;
    edges(2);
    chk("dn_sticky", 8'(fault), 8'h1);
    pulse_reset();
    chk("dn_clear", 8'(fault), 8'h0);

    // 3: door cycle and short reopen
    porta = 1;
    edges(1);
    chk("door_e1_sp", 8'(sp), 8'h1);
    edges(4);
    chk("door_open_sp", 8'(sp), 8'h1);
    porta = 0;
    edges(2);
    chk("door_c2_sp", 8'(sp), 8'h1);
    edges(1);
    chk("door_c3_sp", 8'(sp), 8'h0);
    porta = 1;
    edges(1);
    chk("reopen_sp", 8'(sp), 8'h1);
    porta = 0;
    edges(1);
    chk("reclose_sp", 8'(sp), 8'h0);
    chk("door_nofault", 8'(fault), 8'h0);

    // 4a: motion requested with door open and porta held
    porta = 1;
    edges(3);
    motor2 = 1;
    edges(1);
    chk("uns_a_code", 8'(fault_code), 8'h2);
    chk("uns_a_sens", 8'(sens), 8'h1);
    chk("uns_a_mov", 8'(moving), 8'h0);
    pulse_reset();

    // 4b: porta released as motion starts, door still open
    porta = 1;
    edges(3);
    porta = 0;
    motor2 = 1;
    edges(1);
    chk("uns_b_code", 8'(fault_code), 8'h2);
    chk("uns_b_sp", 8'(sp), 8'h1);
    chk("uns_b_sens", 8'(sens), 8'h1);
    pulse_reset();

    // 5: both motors mid-travel, then async reset
    motor2 = 1;
    edges(5);
    chk("both_pre_sens", 8'(sens), 8'h0);
    motor1 = 1;
    edges(1);
    chk("both_code", 8'(fault_code), 8'h1);
    chk("both_fault", 8'(fault), 8'h1);
    chk("both_sens", 8'(sens), 8'h0);
    motor1 = 0;
    motor2 = 0;
    edges(3);
    chk("both_frozen", 8'(sens), 8'h0);
    chk("both_mov", 8'(moving), 8'h0);
    reset = 1;
    #1;
    chk("async_fault", 8'(fault), 8'h0);
    chk("async_sens", 8'(sens), 8'h1);
    @(negedge clock);
    reset = 0;
    edges(1);
    chk("post_rst_floor", 8'(floor_idx), 8'h0);

    // 6: reversal at pos 3
    motor2 = 1;
    edges(7);
    chk("rev_up_sens", 8'(sens), 8'h0);
    motor2 = 0;
    motor1 = 1;
    edges(1);
    chk("rev_mov", 8'(moving), 8'h1);
    for (int i = 1; i <= 6; i++) begin
      edges(1);
      chk("rev_onehot", 8'($countones(sens) <= 1), 8'h1);
    end
    chk("rev_end_sens", 8'(sens), 8'h1);
    chk("rev_end_flr", 8'(floor_idx), 8'h0);
    motor1 = 0;
    edges(1);
    chk("rev_nofault", 8'(fault), 8'h0);

    // 7: both motors beats unsafe door
    porta = 1;
    edges(3);
    motor1 = 1;
    motor2 = 1;
    edges(1);
    chk("prio_code", 8'(fault_code), 8'h1);
    pulse_reset();

    // 8: overtravel at the top floor
    motor2 = 1;
    edges(25);
    chk("top_sens", 8'(sens), 8'h8);
    chk("top_floor", 8'(floor_idx), 8'h3);
    edges(2);
    chk("top_code", 8'(fault_code), 8'h3);
    chk("top_held", 8'(sens), 8'h8);
    pulse_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
